fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the 8-bit synchronous FIFO (`fifo_mem`). It issues `rd` strobes whenever the FIFO holds data and downstream has room. It captures the one-cycle-latency `data_out` into a 2-entry output buffer and presents words to a downstream consumer over a valid/ready handshake. It also counts drained words and latches FIFO underflow as a sticky error.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; matches the FIFO `data_in`/`data_out` width.
- `CNT_WIDTH`, default 16: width of the drained-word counter.

Ports:
- `clk`  in  1: single clock; all logic rises on the posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: drain enable; when low, no new `fifo_rd` is issued. In-flight and buffered words still drain.
- `fifo_empty`  in  1: FIFO empty flag; reflects reads sampled at the previous edge.
- `fifo_underflow`  in  1: FIFO underflow flag.
- `fifo_data_out`  in  DATA_WIDTH: FIFO read data; valid in the cycle after `fifo_rd` is sampled high.
- `fifo_rd`  out  1: read strobe to the FIFO (`rd`); combinational.
- `m_data`  out  DATA_WIDTH: downstream data, taken from the head of the buffer.
- `m_valid`  out  1: downstream data valid.
- `m_ready`  in  1: downstream ready; a transfer occurs when `m_valid & m_ready` at a posedge.
- `drain_cnt`  out  CNT_WIDTH: number of words accepted downstream since reset.
- `err_underflow`  out  1: sticky; set when `fifo_underflow` is sampled high.

## Operation
- Buffer: 2-entry register FIFO with head/tail pointers and an occupancy state machine.
  - EMPTY (occ 0) → ONE on capture without pop.
  - ONE → TWO on capture without pop.
  - ONE → EMPTY on pop without capture.
  - TWO → ONE on pop without capture.
  - Capture and pop in the same cycle: state unchanged.
- `inflight`: 1-bit register, equal to `fifo_rd` delayed by one cycle.
- Capture: when `inflight` = 1, `fifo_data_out` is written to the tail at the posedge.
- Pop: `m_valid & m_ready`.
- Read issue: `fifo_rd = en & ~fifo_empty & (occ + inflight - pop < 2)`.
  - The arithmetic is 2-bit unsigned and never negative.
  - This guarantees the buffer never overflows, so a captured word is never dropped.
- `m_valid` = (occ != 0). `m_data` = head entry, held stable while `m_valid & ~m_ready`.
- `drain_cnt` increments by 1 on each pop and wraps modulo 2^CNT_WIDTH (0xFFFF → 0x0000).
- `err_underflow` is set on any cycle with `fifo_underflow` = 1. It is cleared only by reset.
- `fifo_rd` is never asserted while `fifo_empty` = 1, so a correct FIFO never underflows from this block.
- Reset values: occ = EMPTY, `inflight` 0, `m_valid` 0, `m_data` 0, `drain_cnt` 0, `err_underflow` 0.
  - `fifo_rd` is 0 while `rst_n` = 0.
  - Reset asserted mid-operation discards buffered and in-flight words. The FIFO is reset by the same `rst_n`.

## Timing
- Read latency:
  - Cycle t: `fifo_rd` high.
  - Cycle t+1: `fifo_data_out` valid, captured at the end of t+1.
  - Cycle t+2: `m_valid` high.
  - So the first word appears 2 cycles after `fifo_empty` falls, with `en` = 1 and `m_ready` = 1.
- Throughput: 1 word per cycle sustained while the FIFO is non-empty and `m_ready` = 1.
- Backpressure:
  - `m_ready` low for N cycles: at most 2 words accumulate and `fifo_rd` stays low until space frees.
  - Reads resume in the same cycle that a pop makes room.
- `en` deasserted: takes effect on `fifo_rd` combinationally in the same cycle. A word already in flight is still captured one cycle later.
- Simultaneous capture and pop with occ = TWO: legal only as a steady pass-through; the read-issue rule prevents a third entry.
- `err_underflow` rises one cycle after `fifo_underflow` is sampled.

## Test plan
- Reset, then write 0x01..0x10 into the FIFO, with `en` = 1 and `m_ready` = 1. Required response:
  - `m_data` sequence 0x01..0x10 in order, one per cycle.
  - First `m_valid` exactly 2 cycles after `fifo_empty` falls.
  - `drain_cnt` = 16.
- Fill the FIFO (`fifo_full`) with `m_ready` held 0 for 20 cycles. Required response:
  - Exactly 2 `fifo_rd` pulses; `m_valid` stays 1 with `m_data` = 0x01 held stable.
  - After `m_ready` rises, 0x01..0x10 arrive with no loss or duplication.
- Toggle `m_ready` 1/0 every cycle during a 16-word drain. Required response:
  - All 16 words delivered in order; occ never exceeds 2; `fifo_rd` never high with `fifo_empty` = 1.
- Drop `en` after 5 reads. Required response:
  - At most 1 further capture; `fifo_rd` stays 0.
  - Buffered words drain; raising `en` again resumes at the next word.
- Assert `rst_n` = 0 with 2 buffered words and 1 in flight. Required response:
  - `m_valid`, `drain_cnt` and `err_underflow` are 0 immediately.
  - No stale word appears after release.
- Force `fifo_underflow` high for one cycle. Required response:
  - `err_underflow` goes 1 the next cycle and stays 1 until reset.
  - Preset `drain_cnt` to 0xFFFF via 65535 transfers, then one more pop: `drain_cnt` = 0x0000.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// rtl/fifo_rd_ctrl_if.sv - FIFO read port and downstream valid/ready bundle for fifo_rd_ctrl
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  // Controller side: reads the FIFO and sources the downstream stream
  modport master (
    input  fifo_empty,
    input  fifo_underflow,
    input  fifo_data_out,
    output fifo_rd,
    output m_data,
    output m_valid,
    input  m_ready
  );

  // Environment side: the FIFO plus the downstream consumer
  modport slave (
    output fifo_empty,
    output fifo_underflow,
    output fifo_data_out,
    input  fifo_rd,
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read-side controller with 2-entry output buffer
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_rd_ctrl_if.master       bus,
  output logic [CNT_WIDTH-1:0] drain_cnt,
  output logic                 err_underflow
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t                  occ;
  logic [1:0]            occ_bits;
  logic                  inflight;
  logic                  capture;
  logic                  pop;
  logic [1:0]            pending;
  logic [DATA_WIDTH-1:0] entry [2];
  logic                  head;
  logic                  tail;

  assign occ_bits = occ;
  assign capture  = inflight;
  assign pop      = bus.m_valid & bus.m_ready;

  // Words that will sit in the buffer after this edge, counting the one in flight.
  // Max is occ 2 + inflight 1 = 3, so 2 bits suffice and pop never drives it negative.
  assign pending  = occ_bits + {1'b0, inflight} - {1'b0, pop};

  // Issue a read only when the buffer is guaranteed room for the returning word
  assign bus.fifo_rd = rst_n & en & ~bus.fifo_empty & (pending < 2'd2);

  assign bus.m_data = entry[head];

  // Occupancy state machine; m_valid is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ         <= OCC_EMPTY;
      bus.m_valid <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (capture) begin
            occ         <= OCC_ONE;
            bus.m_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (capture && !pop) begin
            occ <= OCC_TWO;
          end else if (pop && !capture) begin
            occ         <= OCC_EMPTY;
            bus.m_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (pop && !capture) begin
            occ <= OCC_ONE;
          end
        end
        default: begin
          occ         <= OCC_EMPTY;
          bus.m_valid <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline tracking and buffer storage with head/tail pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      inflight <= bus.fifo_rd;
      if (capture) begin
        entry[tail] <= bus.fifo_data_out;
        tail        <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  // Drained-word counter, wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (pop) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (bus.fifo_underflow) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl with a FIFO model and scoreboard
module tb_fifo_rd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        m_ready;
  logic        wr;
  logic [7:0]  wdata;
  logic        uf_force;
  logic [15:0] drain_cnt;
  logic        err_underflow;

  fifo_rd_ctrl_if #(.DATA_WIDTH(8)) bus ();

  fifo_rd_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .bus           (bus),
    .drain_cnt     (drain_cnt),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: 16 deep, one-cycle read latency, empty from registered count
  logic [7:0] fmem [16];
  logic [3:0] wp, rp;
  logic [4:0] fcount;
  logic [7:0] fdout;
  logic       uf_q;
  logic       do_wr, do_rd;
  logic       fifo_full;

  assign fifo_full          = (fcount == 5'd16);
  assign bus.fifo_empty     = (fcount == 5'd0);
  assign bus.fifo_data_out  = fdout;
  assign bus.fifo_underflow = uf_q | uf_force;
  assign bus.m_ready        = m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; fcount <= '0; fdout <= '0; uf_q <= 1'b0;
    end else begin
      do_wr = wr && (fcount != 5'd16);
      do_rd = bus.fifo_rd && (fcount != 5'd0);
      if (do_wr) begin
        fmem[wp] <= wdata;
        wp       <= wp + 4'd1;
      end
      if (do_rd) begin
        fdout <= fmem[rp];
        rp    <= rp + 4'd1;
      end
      fcount <= fcount + 5'(do_wr) - 5'(do_rd);
      uf_q   <= bus.fifo_rd && (fcount == 5'd0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and monitor state
  logic [7:0] sb [$];
  int   tb_occ, tb_inflight;
  int   rd_pulses, n_pops;
  int   rd_empty_viol = 0, occ_viol = 0, valid_viol = 0, stab_viol = 0;
  int   t_empty_fall, t_valid_rise, first_pop_cyc, last_pop_cyc;
  logic prev_empty, prev_stall, popping;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      tb_occ = 0; tb_inflight = 0; prev_stall = 1'b0; prev_empty = 1'b1;
    end else begin
      if (bus.fifo_rd) begin
        rd_pulses++;
        if (bus.fifo_empty) rd_empty_viol++;
      end
      if (bus.m_valid !== (tb_occ != 0)) valid_viol++;
      if (prev_stall && bus.m_data !== prev_data) stab_viol++;
      popping = bus.m_valid && m_ready;
      if (popping) begin
        n_pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (sb.size() == 0) check("sb_underrun", 32'(sb.size()), 32'd1);
        else check("m_data", 32'(bus.m_data), 32'(sb.pop_front()));
      end
      tb_occ = tb_occ + tb_inflight - (popping ? 1 : 0);
      if (tb_occ > 2) occ_viol++;
      tb_inflight = bus.fifo_rd ? 1 : 0;
      if (prev_empty && !bus.fifo_empty && t_empty_fall < 0) t_empty_fall = cyc;
      if (bus.m_valid && t_valid_rise < 0) t_valid_rise = cyc;
      prev_empty = bus.fifo_empty;
      prev_stall = bus.m_valid && !m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic clear_marks();
    t_empty_fall = -1; t_valid_rise = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    n_pops = 0; rd_pulses = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Writes one word into the FIFO model and records it as expected output
  task automatic push_word(input logic [7:0] d);
    int guard;
    guard = 0;
    while (fifo_full && guard < 500) begin
      step(1);
      guard++;
    end
    if (guard >= 500) check("write_timeout", 32'(guard), 32'd0);
    wr    = 1'b1;
    wdata = d;
    sb.push_back(d);
    step(1);
    wr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int  k;
    bit  done;
    done = 0;
    for (k = 0; k < budget; k++) begin
      if (sb.size() == 0 && !bus.m_valid && bus.fifo_empty) begin
        done = 1;
        break;
      end
      step(1);
    end
    if (!done) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; wr = 1'b0; wdata = '0; uf_force = 1'b0;
    clear_marks();
    step(3);
    // Reset state
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_drain_cnt", 32'(drain_cnt), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    check("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Streaming: latency and one-per-cycle throughput
    clear_marks();
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    wait_drain(100);
    check("first_latency", 32'(t_valid_rise - t_empty_fall), 32'd2);
    check("stream_pops", 32'(n_pops), 32'd16);
    check("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd15);
    check("stream_cnt", 32'(drain_cnt), 32'd16);

    // Backpressure: only two reads while downstream is stalled
    clear_marks();
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    step(6);
    check("bp_rd_pulses", 32'(rd_pulses), 32'd2);
    check("bp_m_valid", 32'(bus.m_valid), 32'd1);
    check("bp_m_data", 32'(bus.m_data), 32'h01);
    m_ready = 1'b1;
    wait_drain(100);
    check("bp_cnt", 32'(drain_cnt), 32'd32);

    // Alternating ready during a 16-word drain
    fork
      begin
        for (int i = 1; i <= 16; i++) push_word(8'(8'h30 + i));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          m_ready = ~m_ready;
          step(1);
        end
      end
    join
    m_ready = 1'b1;
    wait_drain(100);
    check("toggle_cnt", 32'(drain_cnt), 32'd48);

    // Enable dropped after five reads
    en = 1'b0;
    for (int i = 1; i <= 16; i++) push_word(8'(8'h50 + i));
    clear_marks();
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (rd_pulses >= 5) begin
        en = 1'b0;
        break;
      end
    end
    step(10);
    check("en_rd_pulses", 32'(rd_pulses), 32'd5);
    check("en_drained", 32'(drain_cnt), 32'd53);
    check("en_m_valid", 32'(bus.m_valid), 32'd0);
    en = 1'b1;
    wait_drain(100);
    check("en_resume_cnt", 32'(drain_cnt), 32'd64);

    // Sticky underflow
    check("uf_before", 32'(err_underflow), 32'd0);
    uf_force = 1'b1;
    #2;
    check("uf_same_cycle", 32'(err_underflow), 32'd0);
    step(1);
    uf_force = 1'b0;
    check("uf_next_cycle", 32'(err_underflow), 32'd1);
    step(5);
    check("uf_sticky", 32'(err_underflow), 32'd1);

    // Reset with words buffered
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(8'(8'h70 + i));
    step(3);
    check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_cnt", 32'(drain_cnt), 32'd0);
    check("mid_rst_err", 32'(err_underflow), 32'd0);
    check("mid_rst_rd", 32'(bus.fifo_rd), 32'd0);
    step(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    step(3);
    check("post_rst_valid", 32'(bus.m_valid), 32'd0);
    for (int i = 1; i <= 3; i++) push_word(8'(8'hA0 + i));
    wait_drain(100);
    check("post_rst_cnt", 32'(drain_cnt), 32'd3);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) push_word(8'(i));
    wait_drain(200);
    check("cnt_ffff", 32'(drain_cnt), 32'h0000FFFF);
    push_word(8'hEE);
    wait_drain(100);
    check("cnt_wrap", 32'(drain_cnt), 32'd0);

    // Global invariants across the whole run
    check("rd_while_empty", 32'(rd_empty_viol), 32'd0);
    check("occ_over_two", 32'(occ_viol), 32'd0);
    check("valid_vs_occ", 32'(valid_viol), 32'd0);
    check("stall_stability", 32'(stab_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
